// File: rtl/cache_arb_pkg.sv
// Purpose : shared types and constants for the cache fill arbiter.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package cache_arb_pkg;

    // 16-bit words per cache line and default memory read latency.
    localparam int DEF_LINE_WORDS  = 8;
    localparam int DEF_MEM_LATENCY = 4;

    // Index of the last word in a line; the return counter compares against it.
    localparam logic [2:0] LAST_WORD_IDX = 3'(DEF_LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

    // Requester identity; also the encoding of the round-robin 'last' bit.
    typedef logic req_id_t;
    localparam req_id_t REQ_I = 1'b0;
    localparam req_id_t REQ_D = 1'b1;

    // Byte address of word 'idx' within the line holding 'line_addr'.
    // Plain concatenation: a line never crosses a 16-byte boundary.
    function automatic logic [15:0] fill_addr(input logic [15:4] line_addr,
                                              input logic [2:0]  idx);
        return {line_addr, idx, 1'b0};
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Purpose : two-way round-robin chooser between the I and D requesters.
// Latency : combinational.
// Backpressure: none; caller only consults pick when some request is up.
//
// Ports: req_i/req_d request lines, last = side granted most recently,
//        pick = chosen side (REQ_I/REQ_D).
module rr_pick2
    import cache_arb_pkg::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  req_id_t last,
    output req_id_t pick
);

    always_comb begin
        pick = REQ_I;
        if (req_i && req_d) begin
            // Tie: favour whoever did not go last.
            pick = (last == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            pick = REQ_D;
        end
    end

endmodule

// File: rtl/cache_fill_arbiter.sv
// Purpose : shares one main memory between I-cache fills and D-cache fills/write-throughs.
// Latency : grant + first read one cycle after the request is seen idle; fill done with the 8th return.
// Backpressure: requests hold until done; one transaction at a time, one dead IDLE cycle between them.
//
// Ports: clk/rst (sync, active-high);
//        i_req/i_addr -> i_grant/i_data/i_data_valid/i_word/i_done (fills only);
//        d_req/d_wr/d_addr/d_wdata -> d_grant/d_data/d_data_valid/d_word/d_done;
//        mem_en/mem_wr/mem_addr/mem_wdata -> memory, mem_rdata/mem_data_valid <- memory.
module cache_fill_arbiter
    import cache_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_grant,
    output logic [15:0] i_data,
    output logic        i_data_valid,
    output logic [2:0]  i_word,
    output logic        i_done,

    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_grant,
    output logic [15:0] d_data,
    output logic        d_data_valid,
    output logic [2:0]  d_word,
    output logic        d_done,

    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid
);

    arb_state_t  state, state_nxt;
    req_id_t     owner;         // side that holds the current grant
    req_id_t     last;          // side granted most recently
    req_id_t     pick;
    logic [15:1] addr_q;        // fill: line address with [3:1]=0; write: word address
    logic [15:0] wdata_q;
    logic [3:0]  k_cnt;         // reads issued; bit 3 = all issued
    logic [3:0]  r_cnt;         // words returned; bit 3 = line complete
    logic        grab;          // IDLE accepts a request this cycle
    logic        issue;         // fill read issued this cycle
    logic        ret_vld;       // memory word accepted for the owner this cycle
    logic        xfer_done;     // transaction completes this cycle
    logic        busy;

    // Line-offset bits of the I address and the byte bit of the D address never matter.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[3:0], d_addr[0]};

    rr_pick2 u_pick (
        .req_i (i_req),
        .req_d (d_req),
        .last  (last),
        .pick  (pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grab      = 1'b0;
        issue     = 1'b0;
        ret_vld   = 1'b0;
        xfer_done = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            IDLE: begin
                // Any mem_data_valid here is a leftover from an aborted fill.
                if (i_req || d_req) begin
                    grab      = 1'b1;
                    state_nxt = (pick == REQ_D && d_wr) ? WRITE : FILL;
                end
            end
            FILL: begin
                if (!k_cnt[3]) begin
                    issue    = 1'b1;
                    mem_en   = 1'b1;
                    mem_addr = fill_addr(addr_q[15:4], k_cnt[2:0]);
                end
                // Returns are counted independently of issues: the memory is pipelined.
                if (mem_data_valid && !r_cnt[3]) begin
                    ret_vld = 1'b1;
                    if (r_cnt[2:0] == LAST_WORD_IDX) begin
                        xfer_done = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            WRITE: begin
                mem_en    = 1'b1;
                mem_wr    = 1'b1;
                mem_addr  = {addr_q[15:1], 1'b0};
                mem_wdata = wdata_q;
                xfer_done = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner   <= REQ_I;
            last    <= REQ_I;
            addr_q  <= '0;
            wdata_q <= '0;
            k_cnt   <= '0;
            r_cnt   <= '0;
        end else begin
            if (grab) begin
                owner   <= pick;
                last    <= pick;
                wdata_q <= d_wdata;
                k_cnt   <= '0;
                r_cnt   <= '0;
                if (pick == REQ_D && d_wr) begin
                    addr_q <= d_addr[15:1];
                end else if (pick == REQ_D) begin
                    addr_q <= {d_addr[15:4], 3'b000};
                end else begin
                    addr_q <= {i_addr[15:4], 3'b000};
                end
            end
            if (issue) begin
                k_cnt <= k_cnt + 4'd1;
            end
            if (ret_vld) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    assign busy = (state != IDLE);

    assign i_grant      = busy && (owner == REQ_I);
    assign d_grant      = busy && (owner == REQ_D);
    assign i_data_valid = ret_vld && (owner == REQ_I);
    assign d_data_valid = ret_vld && (owner == REQ_D);
    assign i_done       = xfer_done && (owner == REQ_I);
    assign d_done       = xfer_done && (owner == REQ_D);

    // Both data buses just mirror memory; the valids qualify them.
    assign i_data = mem_rdata;
    assign d_data = mem_rdata;
    assign i_word = r_cnt[2:0];
    assign d_word = r_cnt[2:0];

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Purpose : directed + randomized bench for cache_fill_arbiter against a transaction-level model.
// Latency : model predicts every output from the cycle offset within the current transaction.
// Backpressure: requesters hold req until done (or drop it early after grant).
`timescale 1ns/1ps
module tb_cache_fill_arbiter;
    import cache_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        i_grant, i_data_valid, i_done;
    logic [15:0] i_data;
    logic [2:0]  i_word;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        d_grant, d_data_valid, d_done;
    logic [15:0] d_data;
    logic [2:0]  d_word;
    logic        mem_en, mem_wr;
    logic [15:0] mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_data_valid = 1'b0;

    always #5 clk = ~clk;

    cache_fill_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_data(i_data),
        .i_data_valid(i_data_valid), .i_word(i_word), .i_done(i_done),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_grant(d_grant), .d_data(d_data), .d_data_valid(d_data_valid),
        .d_word(d_word), .d_done(d_done),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_data_valid(mem_data_valid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Memory contents are a fixed function of the byte address.
    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    // Memory: a read seen at a clock edge returns DEF_MEM_LATENCY cycles after the issue cycle.
    // Stray valids with junk data are injected only into cycles the model expects to be idle.
    localparam int PD = DEF_MEM_LATENCY - 1;
    logic        pipe_vld [PD] = '{default: 1'b0};
    logic [15:0] pipe_dat [PD] = '{default: 16'h0};
    bit          spur_en   = 1'b0;
    bit          spur_next = 1'b0;

    always @(posedge clk) begin
        pipe_vld[0] <= mem_en && !mem_wr;
        pipe_dat[0] <= mem_fn(mem_addr);
        for (int s = 1; s < PD; s++) begin
            pipe_vld[s] <= pipe_vld[s-1];
            pipe_dat[s] <= pipe_dat[s-1];
        end
        mem_data_valid <= pipe_vld[PD-1] | spur_next;
        mem_rdata      <= pipe_vld[PD-1] ? pipe_dat[PD-1] : 16'($urandom);
    end

    // Transaction-level reference model.
    bit          m_act = 1'b0;
    int          m_t0 = 0;
    int          m_len = 0;
    bit          m_own_d = 1'b0;
    bit          m_wr = 1'b0;
    bit          m_last_d = 1'b0;
    logic [15:0] m_addr = '0;
    logic [15:0] m_wd = '0;

    bit e_ig, e_dg, e_idn, e_ddn;

    function automatic bit model_active(input int c);
        return m_act && (c > m_t0) && (c <= m_t0 + m_len);
    endfunction

    task automatic check_outputs();
        bit          act, v, dn, en, wr;
        int          off;
        logic [15:0] ea, ewd, edat;
        logic [2:0]  ew;
        act = model_active(cyc);
        off = cyc - m_t0;
        v = 0; dn = 0; en = 0; wr = 0; ea = '0; ewd = '0; edat = '0; ew = '0;
        if (act && m_wr) begin
            en = 1; wr = 1; ea = {m_addr[15:1], 1'b0}; ewd = m_wd; dn = 1;
        end else if (act) begin
            if (off <= DEF_LINE_WORDS) begin
                en = 1;
                ea = {m_addr[15:4], 3'(off - 1), 1'b0};
            end
            if (off > DEF_MEM_LATENCY) begin
                v    = 1;
                ew   = 3'(off - DEF_MEM_LATENCY - 1);
                edat = mem_fn({m_addr[15:4], ew, 1'b0});
            end
            dn = (off == m_len);
        end
        e_ig  = act && !m_own_d;
        e_dg  = act && m_own_d;
        e_idn = dn && !m_own_d;
        e_ddn = dn && m_own_d;
        check("i_grant",      32'(i_grant),      32'(e_ig));
        check("d_grant",      32'(d_grant),      32'(e_dg));
        check("i_data_valid", 32'(i_data_valid), 32'(v && !m_own_d));
        check("d_data_valid", 32'(d_data_valid), 32'(v && m_own_d));
        check("i_done",       32'(i_done),       32'(e_idn));
        check("d_done",       32'(d_done),       32'(e_ddn));
        check("mem_en",       32'(mem_en),       32'(en));
        check("mem_wr",       32'(mem_wr),       32'(wr));
        check("mem_addr",     32'(mem_addr),     32'(ea));
        check("mem_wdata",    32'(mem_wdata),    32'(ewd));
        if (v && !m_own_d) begin
            check("i_data", 32'(i_data), 32'(edat));
            check("i_word", 32'(i_word), 32'(ew));
        end
        if (v && m_own_d) begin
            check("d_data", 32'(d_data), 32'(edat));
            check("d_word", 32'(d_word), 32'(ew));
        end
    endtask

    // Apply the arbitration rules to the inputs the coming edge will sample.
    task automatic model_sample();
        if (rst) begin
            m_act    = 0;
            m_last_d = 0;
        end else if (!model_active(cyc) && (i_req || d_req)) begin
            m_own_d  = (i_req && d_req) ? !m_last_d : d_req;
            m_last_d = m_own_d;
            m_act    = 1;
            m_t0     = cyc;
            m_wr     = m_own_d && d_wr;
            m_addr   = m_own_d ? d_addr : i_addr;
            m_wd     = d_wdata;
            m_len    = m_wr ? 1 : DEF_LINE_WORDS + DEF_MEM_LATENCY;
        end
        spur_next = spur_en && !model_active(cyc + 1) && ($urandom_range(0, 3) == 0);
    endtask

    // Inputs are driven just after a falling edge; outputs are checked at the next one.
    task automatic step();
        model_sample();
        @(negedge clk);
        cyc++;
        check_outputs();
    endtask

    initial begin
        int n, t_req, t_d, cnt, mcnt, quiet;
        bit seen;
        bit prev_ig, prev_dg;
        bit order [$];

        rst = 1;
        repeat (3) step();
        rst = 0;
        step();

        // D fill alone.
        t_req = cyc; d_req = 1; d_wr = 0; d_addr = 16'h1236;
        n = 0;
        while (d_done !== 1'b1 && n < 40) begin step(); n++; end
        check("dfill_done_lat", 32'(cyc - t_req), 32'd12);
        d_req = 0;
        repeat (3) step();

        // D write alone.
        t_req = cyc; d_req = 1; d_wr = 1; d_addr = 16'h00A5; d_wdata = 16'hBEEF;
        n = 0;
        while (d_done !== 1'b1 && n < 20) begin step(); n++; end
        check("dwr_done_lat", 32'(cyc - t_req), 32'd1);
        check("dwr_mem_addr", 32'(mem_addr), 32'h00A4);
        check("dwr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        d_req = 0; d_wr = 0;
        repeat (2) step();

        // Both raised from reset: D first, I after exactly one dead cycle.
        rst = 1; step(); rst = 0;
        t_req = cyc; i_req = 1; i_addr = 16'h4A7C; d_req = 1; d_wr = 0; d_addr = 16'h8010;
        n = 0;
        while (d_done !== 1'b1 && n < 40) begin step(); n++; end
        check("tie_d_done_lat", 32'(cyc - t_req), 32'd12);
        d_req = 0; t_d = cyc;
        n = 0;
        while (i_grant !== 1'b1 && n < 20) begin step(); n++; end
        check("tie_i_grant_gap", 32'(cyc - t_d), 32'd2);
        n = 0;
        while (i_done !== 1'b1 && n < 40) begin step(); n++; end
        check("tie_i_done_seen", 32'(i_done), 32'd1);
        i_req = 0;
        repeat (2) step();

        // Back-to-back D writes with I held: grants alternate D, I, D.
        i_req = 1; i_addr = 16'hC0DE; d_req = 1; d_wr = 1; d_addr = 16'h0102; d_wdata = 16'h1111;
        prev_ig = 0; prev_dg = 0; n = 0;
        while (order.size() < 3 && n < 80) begin
            step(); n++;
            if (i_grant && !prev_ig) order.push_back(1'b0);
            if (d_grant && !prev_dg) order.push_back(1'b1);
            prev_ig = i_grant; prev_dg = d_grant;
            if (d_done) d_wdata = d_wdata + 16'h1;
        end
        i_req = 0; d_req = 0; d_wr = 0;
        check("rr_grant_count", 32'(order.size()), 32'd3);
        if (order.size() == 3) begin
            check("rr_order0", 32'(order[0]), 32'd1);
            check("rr_order1", 32'(order[1]), 32'd0);
            check("rr_order2", 32'(order[2]), 32'd1);
        end
        repeat (2) step();

        // Reset at the third returned word of an I fill.
        i_req = 1; i_addr = 16'h7770;
        cnt = 0; n = 0;
        while (cnt < 3 && n < 40) begin step(); n++; if (i_data_valid) cnt++; end
        check("rst_words_before", 32'(cnt), 32'd3);
        rst = 1; i_req = 0;
        cnt = 0; mcnt = 0;
        step();
        rst = 0;
        if (i_data_valid) cnt++;
        if (mem_data_valid) mcnt++;
        repeat (8) begin
            step();
            if (i_data_valid) cnt++;
            if (mem_data_valid) mcnt++;
        end
        check("rst_no_stale_vld", 32'(cnt), 32'd0);
        check("rst_stale_returns", 32'(mcnt > 0), 32'd1);

        // I req dropped right after grant still completes.
        i_req = 1; i_addr = 16'h2468;
        n = 0;
        while (i_grant !== 1'b1 && n < 20) begin step(); n++; end
        i_req = 0;
        cnt = (i_data_valid === 1'b1) ? 1 : 0;
        seen = 0; n = 0;
        while (!seen && n < 40) begin
            step(); n++;
            if (i_data_valid) cnt++;
            if (i_done) seen = 1;
        end
        check("drop_done_seen", 32'(seen), 32'd1);
        check("drop_word_count", 32'(cnt), 32'd8);
        step();
        check("drop_grant_low", 32'(i_grant), 32'd0);
        repeat (2) step();

        // Randomized traffic with stray returns and occasional resets.
        spur_en = 1; quiet = 0;
        for (int k = 0; k < 3000; k++) begin
            if (rst) begin
                rst = 0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1; i_req = 0; d_req = 0; quiet = 10;
            end
            if (quiet > 0) quiet--;
            if (!rst) begin
                if (i_req && (e_idn || (e_ig && $urandom_range(0, 9) == 0))) begin
                    i_req = 0;
                end else if (!i_req && quiet == 0 && $urandom_range(0, 3) == 0) begin
                    i_req = 1; i_addr = 16'($urandom);
                end
                if (d_req && (e_ddn || (e_dg && $urandom_range(0, 9) == 0))) begin
                    d_req = 0;
                end else if (!d_req && quiet == 0 && $urandom_range(0, 3) == 0) begin
                    d_req = 1; d_wr = 1'($urandom_range(0, 1));
                    d_addr = 16'($urandom); d_wdata = 16'($urandom);
                end
            end
            step();
        end
        spur_en = 0; rst = 0; i_req = 0; d_req = 0;
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
